// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared parameters and types for the FFT butterfly stages
package fft_pkg;

  localparam int WIDTH_IN  = 15;
  localparam int WIDTH_OUT = WIDTH_IN + 1;
  localparam int DEPTH     = 8;
  localparam int DELAY     = 4;

  typedef logic signed [WIDTH_IN-1:0]  sample_in_t;
  typedef logic signed [WIDTH_OUT-1:0] sample_out_t;

  typedef struct packed {
    sample_in_t [DEPTH-1:0] r;
    sample_in_t [DEPTH-1:0] q;
  } cvec_in_t;

  typedef enum logic {FILL = 1'b0, COMBINE = 1'b1} phase_e;

  // Pair-index width; a single-slot buffer still gets a 1-bit index.
  function automatic int idx_width(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction

endpackage

// File: rtl/fft_bfly2_delay_if.sv
// rtl/fft_bfly2_delay_if.sv - vector input and butterfly output bundle
interface fft_bfly2_delay_if #(
  parameter int WIDTH_IN  = fft_pkg::WIDTH_IN,
  parameter int WIDTH_OUT = fft_pkg::WIDTH_OUT,
  parameter int DEPTH     = fft_pkg::DEPTH,
  parameter int DELAY     = fft_pkg::DELAY
);
  localparam int IDX_W = fft_pkg::idx_width(DELAY);

  logic                            din_valid;
  logic                            din_sop;
  logic [DEPTH-1:0][WIDTH_IN-1:0]  din_R;
  logic [DEPTH-1:0][WIDTH_IN-1:0]  din_Q;
  logic                            dout_valid;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] dout_R_add;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] dout_Q_add;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] dout_R_sub;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] dout_Q_sub;
  logic [IDX_W-1:0]                dout_idx;

  modport master (
    output din_valid, din_sop, din_R, din_Q,
    input  dout_valid, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub, dout_idx
  );

  modport slave (
    input  din_valid, din_sop, din_R, din_Q,
    output dout_valid, dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub, dout_idx
  );

endinterface

// File: rtl/fft_delay_buf.sv
// rtl/fft_delay_buf.sv - first-half vector store, registered write, combinational read
module fft_delay_buf #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8,
  parameter int DELAY = 4,
  parameter int AW    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we_i,
  input  logic [AW-1:0]                waddr_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  wdata_r_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  wdata_q_i,
  input  logic [AW-1:0]                raddr_i,
  output logic [DEPTH-1:0][WIDTH-1:0]  rdata_r_o,
  output logic [DEPTH-1:0][WIDTH-1:0]  rdata_q_o
);
  import fft_pkg::*;

  logic [DEPTH-1:0][WIDTH-1:0] mem_r_q [DELAY];
  logic [DEPTH-1:0][WIDTH-1:0] mem_q_q [DELAY];

  // Clearing every slot on reset makes a read of a never-written slot return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        mem_r_q[i] <= '0;
        mem_q_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_r_q[waddr_i] <= wdata_r_i;
      mem_q_q[waddr_i] <= wdata_q_i;
    end
  end

  assign rdata_r_o = mem_r_q[raddr_i];
  assign rdata_q_o = mem_q_q[raddr_i];

endmodule

// File: rtl/fft_bfly2_delay.sv
// rtl/fft_bfly2_delay.sv - radix-2 delay-feedback butterfly, <7.6> in, <8.6> sum/difference out
module fft_bfly2_delay #(
  parameter int WIDTH_IN  = fft_pkg::WIDTH_IN,
  parameter int WIDTH_OUT = fft_pkg::WIDTH_OUT,
  parameter int DEPTH     = fft_pkg::DEPTH,
  parameter int DELAY     = fft_pkg::DELAY
) (
  input logic              clk,
  input logic              rst_n,
  fft_bfly2_delay_if.slave bus
);
  import fft_pkg::*;

  localparam int IDX_W = idx_width(DELAY);
  localparam int CNT_W = $clog2(2 * DELAY);
  localparam logic [CNT_W-1:0] K_MASK = CNT_W'(DELAY - 1);

  function automatic logic [WIDTH_OUT-1:0] sext(input logic [WIDTH_IN-1:0] x);
    return {{(WIDTH_OUT - WIDTH_IN){x[WIDTH_IN-1]}}, x};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  phase_e           phase;
  logic [IDX_W-1:0] k;
  logic             fill_we;
  logic             fire;

  logic [DEPTH-1:0][WIDTH_IN-1:0]  buf_r, buf_q;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] add_r_d, add_q_d, sub_r_d, sub_q_d;
  logic [DEPTH-1:0][WIDTH_OUT-1:0] add_r_q, add_q_q, sub_r_q, sub_q_q;
  logic                            valid_q;
  logic [IDX_W-1:0]                idx_q;

  // SOP forces position 0 so a partial frame is simply abandoned.
  // 2*DELAY is a power of two, so the counter top bit is the phase and it wraps naturally.
  always_comb begin
    cnt_eff = bus.din_sop ? '0 : cnt_q;
    phase   = cnt_eff[CNT_W-1] ? COMBINE : FILL;
    k       = IDX_W'(cnt_eff & K_MASK);
    cnt_d   = bus.din_valid ? cnt_eff + CNT_W'(1) : cnt_q;
    fill_we = bus.din_valid && (phase == FILL);
    fire    = bus.din_valid && (phase == COMBINE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  fft_delay_buf #(
    .WIDTH (WIDTH_IN),
    .DEPTH (DEPTH),
    .DELAY (DELAY),
    .AW    (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (fill_we),
    .waddr_i   (k),
    .wdata_r_i (bus.din_R),
    .wdata_q_i (bus.din_Q),
    .raddr_i   (k),
    .rdata_r_o (buf_r),
    .rdata_q_o (buf_q)
  );

  // One extra bit of headroom makes both sum and difference exact.
  always_comb begin
    add_r_d = '0;
    add_q_d = '0;
    sub_r_d = '0;
    sub_q_d = '0;
    for (int l = 0; l < DEPTH; l++) begin
      add_r_d[l] = sext(buf_r[l]) + sext(bus.din_R[l]);
      add_q_d[l] = sext(buf_q[l]) + sext(bus.din_Q[l]);
      sub_r_d[l] = sext(buf_r[l]) - sext(bus.din_R[l]);
      sub_q_d[l] = sext(buf_q[l]) - sext(bus.din_Q[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      add_r_q <= '0;
      add_q_q <= '0;
      sub_r_q <= '0;
      sub_q_q <= '0;
    end else begin
      valid_q <= fire;
      if (fire) begin
        idx_q   <= k;
        add_r_q <= add_r_d;
        add_q_q <= add_q_d;
        sub_r_q <= sub_r_d;
        sub_q_q <= sub_q_d;
      end
    end
  end

  assign bus.dout_valid = valid_q;
  assign bus.dout_idx   = idx_q;
  assign bus.dout_R_add = add_r_q;
  assign bus.dout_Q_add = add_q_q;
  assign bus.dout_R_sub = sub_r_q;
  assign bus.dout_Q_sub = sub_q_q;

endmodule

// File: tb/tb_fft_bfly2_delay.sv
// tb/tb_fft_bfly2_delay.sv - directed-vector bench for the delay-feedback butterfly
module tb_fft_bfly2_delay;
  import fft_pkg::*;

  typedef logic [7:0][15:0] ovec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  fft_bfly2_delay_if #(.DELAY(4)) a_if ();
  fft_bfly2_delay_if #(.DELAY(1)) b_if ();

  fft_bfly2_delay #(.DELAY(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  fft_bfly2_delay #(.DELAY(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  always #5 clk = ~clk;

  function automatic ovec_t splat(input int base, input int step);
    ovec_t v;
    for (int l = 0; l < 8; l++) v[l] = 16'(base + l * step);
    return v;
  endfunction

  task automatic drive_a(input bit v, input bit s, input int r, input int q, input int dr, input int dq);
    a_if.din_valid = v;
    a_if.din_sop   = s;
    for (int l = 0; l < 8; l++) begin
      a_if.din_R[l] = 15'(r + l * dr);
      a_if.din_Q[l] = 15'(q + l * dq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input bit v, input bit s, input int r, input int q, input int dr, input int dq);
    b_if.din_valid = v;
    b_if.din_sop   = s;
    for (int l = 0; l < 8; l++) begin
      b_if.din_R[l] = 15'(r + l * dr);
      b_if.din_Q[l] = 15'(q + l * dq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (a_if.dout_valid !== 1'b0 || a_if.dout_idx !== 2'd0 ||
          {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== 512'd0) begin
        n_err++;
        $display("FAIL reset_a step %0d: got v=%b idx=%0d data=%h want v=0 idx=0 data=0", i,
                 a_if.dout_valid, a_if.dout_idx, {a_if.dout_R_add, a_if.dout_Q_add});
      end
      n_vec++;
      if (b_if.dout_valid !== 1'b0 || b_if.dout_idx !== 1'd0 ||
          {b_if.dout_R_add, b_if.dout_Q_add, b_if.dout_R_sub, b_if.dout_Q_sub} !== 512'd0) begin
        n_err++;
        $display("FAIL reset_b step %0d: got v=%b idx=%0d want v=0 idx=0 data=0", i,
                 b_if.dout_valid, b_if.dout_idx);
      end
      if (i == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_basic();
    ovec_t e_ra, e_qa, e_rs, e_qs;
    for (int v = 0; v < 4; v++) begin
      drive_a(1'b1, v == 0, 64, 0, 0, 0);
      n_vec++;
      if (a_if.dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_fill v%0d: got dout_valid=%b want 0", v, a_if.dout_valid);
      end
    end
    e_ra = splat(96, 0);
    e_qa = splat(-32, 0);
    e_rs = splat(32, 0);
    e_qs = splat(32, 0);
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 1'b0, 32, -32, 0, 0);
      n_vec++;
      if (a_if.dout_valid !== 1'b1 || a_if.dout_idx !== 2'(k) ||
          {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== {e_ra, e_qa, e_rs, e_qs}) begin
        n_err++;
        $display("FAIL basic_pair k=%0d: got v=%b idx=%0d add=%h/%h sub=%h/%h want idx=%0d add=%h/%h sub=%h/%h",
                 k, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_add,
                 a_if.dout_R_sub, a_if.dout_Q_sub, k, e_ra, e_qa, e_rs, e_qs);
      end
    end
    drive_a(1'b0, 1'b0, 0, 0, 0, 0);
    n_vec++;
    if (a_if.dout_valid !== 1'b0 || a_if.dout_R_add !== e_ra) begin
      n_err++;
      $display("FAIL basic_idle: got v=%b add_r=%h want v=0 add_r=%h", a_if.dout_valid, a_if.dout_R_add, e_ra);
    end
  endtask

  task automatic test_extremes();
    ovec_t e_a, e_s;
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, k == 0, (k < 2) ? 16383 : -16384, (k < 2) ? 16383 : -16384, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 1'b0, (k < 2) ? -16384 : 16383, (k < 2) ? -16384 : 16383, 0, 0);
      e_a = splat(-1, 0);
      e_s = splat((k < 2) ? 32767 : -32767, 0);
      n_vec++;
      if (a_if.dout_valid !== 1'b1 || a_if.dout_idx !== 2'(k) ||
          {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== {e_a, e_a, e_s, e_s}) begin
        n_err++;
        $display("FAIL extremes k=%0d: got v=%b idx=%0d add_r=%h sub_r=%h sub_q=%h want add=%h sub=%h",
                 k, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_R_sub, a_if.dout_Q_sub, e_a, e_s);
      end
    end
  endtask

  task automatic test_gapped();
    ovec_t e_ra, e_qa, e_rs, e_qs;
    for (int v = 0; v < 8; v++) begin
      if (v == 6) begin
        for (int g = 0; g < 3; g++) begin
          drive_a(1'b0, 1'b0, 777, -777, 3, 5);
          n_vec++;
          if (a_if.dout_valid !== 1'b0 || a_if.dout_idx !== 2'd1 || a_if.dout_R_add !== e_ra ||
              a_if.dout_Q_sub !== e_qs) begin
            n_err++;
            $display("FAIL gap_hold g=%0d: got v=%b idx=%0d add_r=%h sub_q=%h want v=0 idx=1 add_r=%h sub_q=%h",
                     g, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_sub, e_ra, e_qs);
          end
        end
      end
      drive_a(1'b1, v == 0, 100 * v, -50 * v, 1, -1);
      if (v < 4) begin
        n_vec++;
        if (a_if.dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL gap_fill v%0d: got dout_valid=%b want 0", v, a_if.dout_valid);
        end
      end else begin
        e_ra = splat(200 * (v - 4) + 400, 2);
        e_rs = splat(-400, 0);
        e_qa = splat(-100 * (v - 4) - 200, -2);
        e_qs = splat(200, 0);
        n_vec++;
        if (a_if.dout_valid !== 1'b1 || a_if.dout_idx !== 2'(v - 4) ||
            {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== {e_ra, e_qa, e_rs, e_qs}) begin
          n_err++;
          $display("FAIL gap_pair k=%0d: got v=%b idx=%0d add=%h/%h sub=%h/%h want add=%h/%h sub=%h/%h",
                   v - 4, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_add,
                   a_if.dout_R_sub, a_if.dout_Q_sub, e_ra, e_qa, e_rs, e_qs);
        end
      end
    end
  endtask

  task automatic test_resync();
    ovec_t e_ra, e_qa, e_rs, e_qs;
    int fb;
    for (int v = 0; v < 2; v++) begin
      drive_a(1'b1, v == 0, 5000, 5000, 0, 0);
      n_vec++;
      if (a_if.dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL resync_stale v%0d: got dout_valid=%b want 0", v, a_if.dout_valid);
      end
    end
    for (int f = 0; f < 2; f++) begin
      fb = (f == 0) ? 300 : 600;
      for (int k = 0; k < 4; k++) begin
        drive_a(1'b1, k == 0, fb + 10 * k, -20, 1, 0);
        n_vec++;
        if (a_if.dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL resync_fill f%0d k%0d: got dout_valid=%b want 0", f, k, a_if.dout_valid);
        end
      end
      for (int k = 0; k < ((f == 0) ? 1 : 4); k++) begin
        drive_a(1'b1, 1'b0, -100, 40, 3, -1);
        e_ra = splat(fb - 100 + 10 * k, 4);
        e_rs = splat(fb + 100 + 10 * k, -2);
        e_qa = splat(20, -1);
        e_qs = splat(-60, 1);
        n_vec++;
        if (a_if.dout_valid !== 1'b1 || a_if.dout_idx !== 2'(k) ||
            {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== {e_ra, e_qa, e_rs, e_qs}) begin
          n_err++;
          $display("FAIL resync_pair f%0d k=%0d: got v=%b idx=%0d add=%h/%h sub=%h/%h want add=%h/%h sub=%h/%h",
                   f, k, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_add,
                   a_if.dout_R_sub, a_if.dout_Q_sub, e_ra, e_qa, e_rs, e_qs);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    ovec_t e_ra, e_qa, e_rs, e_qs;
    for (int v = 0; v < 6; v++) drive_a(1'b1, v == 0, (v < 4) ? 1000 : 1, (v < 4) ? 1000 : 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (a_if.dout_valid !== 1'b0 || a_if.dout_idx !== 2'd0 ||
        {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== 512'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: got v=%b idx=%0d add=%h/%h want all 0",
               a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_add);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 8; v++) begin
      if (v < 4) begin
        drive_a(1'b1, 1'b0, -2000 + 10 * v, 7, 0, 1);
        n_vec++;
        if (a_if.dout_valid !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_fill v%0d: got dout_valid=%b want 0", v, a_if.dout_valid);
        end
      end else begin
        drive_a(1'b1, 1'b0, 500, -3, 0, 0);
        e_ra = splat(-1500 + 10 * (v - 4), 0);
        e_rs = splat(-2500 + 10 * (v - 4), 0);
        e_qa = splat(4, 1);
        e_qs = splat(10, 1);
        n_vec++;
        if (a_if.dout_valid !== 1'b1 || a_if.dout_idx !== 2'(v - 4) ||
            {a_if.dout_R_add, a_if.dout_Q_add, a_if.dout_R_sub, a_if.dout_Q_sub} !== {e_ra, e_qa, e_rs, e_qs}) begin
          n_err++;
          $display("FAIL reset_mid_pair k=%0d: got v=%b idx=%0d add=%h/%h sub=%h/%h want add=%h/%h sub=%h/%h",
                   v - 4, a_if.dout_valid, a_if.dout_idx, a_if.dout_R_add, a_if.dout_Q_add,
                   a_if.dout_R_sub, a_if.dout_Q_sub, e_ra, e_qa, e_rs, e_qs);
        end
      end
    end
  endtask

  task automatic test_delay1();
    int ar[3]  = '{1000, -16384, 16383};
    int adr[3] = '{1, 1, -1};
    int aq[3]  = '{-7, 16383, 0};
    int br[3]  = '{-300, 16383, -16384};
    int bq[3]  = '{25, -16384, 1};
    ovec_t e_ra, e_qa, e_rs, e_qs;
    a_if.din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_b(1'b1, 1'b0, ar[i], aq[i], adr[i], 0);
      n_vec++;
      if (b_if.dout_valid !== 1'b0) begin
        n_err++;
        $display("FAIL delay1_a i%0d: got dout_valid=%b want 0", i, b_if.dout_valid);
      end
      drive_b(1'b1, 1'b0, br[i], bq[i], 0, 0);
      e_ra = splat(ar[i] + br[i], adr[i]);
      e_rs = splat(ar[i] - br[i], adr[i]);
      e_qa = splat(aq[i] + bq[i], 0);
      e_qs = splat(aq[i] - bq[i], 0);
      n_vec++;
      if (b_if.dout_valid !== 1'b1 || b_if.dout_idx !== 1'd0 ||
          {b_if.dout_R_add, b_if.dout_Q_add, b_if.dout_R_sub, b_if.dout_Q_sub} !== {e_ra, e_qa, e_rs, e_qs}) begin
        n_err++;
        $display("FAIL delay1_pair i%0d: got v=%b idx=%0d add=%h/%h sub=%h/%h want add=%h/%h sub=%h/%h",
                 i, b_if.dout_valid, b_if.dout_idx, b_if.dout_R_add, b_if.dout_Q_add,
                 b_if.dout_R_sub, b_if.dout_Q_sub, e_ra, e_qa, e_rs, e_qs);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    a_if.din_valid = 1'b0;
    a_if.din_sop   = 1'b0;
    a_if.din_R     = '0;
    a_if.din_Q     = '0;
    b_if.din_valid = 1'b0;
    b_if.din_sop   = 1'b0;
    b_if.din_R     = '0;
    b_if.din_Q     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_gapped();
    test_resync();
    test_reset_mid();
    test_delay1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_bfly2_delay.md
# fft_bfly2_delay

Radix-2 delay-feedback butterfly stage that sits directly downstream of the stage-1 twiddle multiplier, consuming one of its 8-lane complex output groups in <7.6> format. It buffers the first half of each 2·DELAY-vector frame and combines each vector from the second half with its buffered partner. It emits the sum and difference vectors in <8.6> to the next twiddle/butterfly stage. Four instances cover the four multiplier output groups.

## Interface
- WIDTH_IN, 15, input sample width per real/imag part, signed <7.6>
- WIDTH_OUT, 16, output sample width, signed <8.6> (WIDTH_IN+1)
- DEPTH, 8, number of parallel lanes per vector
- DELAY, 4, butterfly distance in vectors; must be a power of two ≥1
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din_valid  input  1  input vector valid this cycle
- din_sop  input  1  first vector of a frame; qualified by din_valid
- din_R  input  DEPTH×WIDTH_IN  real parts, signed
- din_Q  input  DEPTH×WIDTH_IN  imaginary parts, signed
- dout_valid  output  1  output vectors valid
- dout_R_add, dout_Q_add  output  DEPTH×WIDTH_OUT  buf + din
- dout_R_sub, dout_Q_sub  output  DEPTH×WIDTH_OUT  buf − din
- dout_idx  output  log2(DELAY) (min 1)  pair index k of the current output, 0..DELAY−1

## Operation
- Frame counter cnt, range 0..2·DELAY−1. It advances only on din_valid and wraps from 2·DELAY−1 to 0.
- din_valid with din_sop: the vector is treated as cnt=0, whatever cnt held, and cnt becomes 1. A partial frame in progress is discarded with no output and no error.
- FILL phase (effective cnt < DELAY): write din_R/din_Q into buffer slot cnt. No output.
- COMBINE phase (effective cnt ≥ DELAY): read slot k=cnt−DELAY.
  - add = sext(buf)+sext(din) and sub = sext(buf)−sext(din), per lane, for R and Q independently.
  - Results are registered, with dout_valid=1 and dout_idx=k.
- Arithmetic: sign-extend both operands to WIDTH_OUT, then add or subtract exactly. No rounding, no saturation; the result cannot overflow.
- din_valid low: cnt and buffer hold. dout_valid goes 0 the next cycle. Data outputs hold their last value.
- No backpressure. The consumer must accept every cycle dout_valid=1.
- Buffer slots are overwritten only in FILL. A COMBINE read of a slot never written since reset returns 0.

## Timing
- Reset: cnt=0, all buffer slots 0, dout_valid=0, dout_idx=0, all dout_* data 0.
- Latency: a COMBINE-phase input at cycle t gives dout_valid=1 with its results at cycle t+1.
- A buffered vector written at cycle t can be read by a COMBINE input at cycle t+1 or later (DELAY=1 back-to-back is legal).
- Throughput: with continuous din_valid, output is DELAY valid cycles followed by DELAY idle cycles per frame.
- din_sop in a COMBINE-phase position:
  - The remaining pairs of the old frame are dropped.
  - An output already registered from the previous cycle still presents normally.
- Reset asserted mid-frame: everything clears immediately (asynchronously). The first valid vector after release is cnt=0, with or without din_sop.

## Structure
- Shared package fft_pkg:
  - Localparams WIDTH_IN, WIDTH_OUT, DEPTH, DELAY defaults.
  - Typedefs for a lane sample in <7.6> and <8.6>.
  - Typedef for a complex DEPTH-lane vector.
  - Phase enum {FILL, COMBINE}.
- Sub-module fft_delay_buf:
  - DELAY×DEPTH×2 register array.
  - Synchronous write port (we, waddr), combinational read port (raddr).
  - Async reset to 0.
- The top holds the counter and phase decode, the butterfly adders and the output registers.

## Test plan
- Reset values: assert rst_n=0 mid-frame with outputs nonzero → all outputs 0 immediately; first vector after release is treated as cnt=0.
- Basic pair, DELAY=4, continuous valid, 8 vectors:
  - Vectors 0–3 have all lanes R=64 (1.0), Q=0; vectors 4–7 have all lanes R=32, Q=−32.
  - Expect dout_valid on cycles 5–8 (one cycle after each of vectors 4–7), dout_idx 0..3.
  - Expect add R=96, Q=−32; sub R=32, Q=32.
- Extremes:
  - Buffered R=Q=16383, then R=Q=−16384: add=−1, sub=32767.
  - Buffered −16384, then 16383: add=−1, sub=−32767.
  - All exact in 16 bits, no wrap.
- Gapped input: deassert din_valid for 3 cycles between vectors 5 and 6 → cnt holds, dout_valid 0 during the gap, outputs hold, pairs 2–3 still correct.
- Resync: assert din_sop at vector 2 of a frame → the old partial frame produces no output; the new frame pairs correctly and dout_idx restarts at 0.
- DELAY=1 back-to-back: alternate vectors a, b, a, b → dout_valid=1 on every second cycle, add=a+b, sub=a−b.
